// File: rtl/mc_control_fsm.sv
// Multi-cycle RISC-V control FSM: sequences fetch/decode/execute and drives datapath selects.
// Flags illegal encodings and memory-wait timeouts; both are sticky until reset.
module mc_control_fsm #(
   parameter int unsigned MEM_WAIT_MAX    = 15,
   parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       Zero,
   input  logic       ALUR31,
   input  logic       carryout,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       MemWrite,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] ResultSrc,
   output logic [2:0] ImmSrc,
   output logic [3:0] state,
   output logic       illegal,
   output logic       timeout
);

   localparam int unsigned CntW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
   localparam logic [CntW-1:0] WaitMax = CntW'(MEM_WAIT_MAX);

   localparam logic [6:0] OpLoad  = 7'b0000011;
   localparam logic [6:0] OpStore = 7'b0100011;
   localparam logic [6:0] OpR     = 7'b0110011;
   localparam logic [6:0] OpI     = 7'b0010011;
   localparam logic [6:0] OpBr    = 7'b1100011;
   localparam logic [6:0] OpJal   = 7'b1101111;
   localparam logic [6:0] OpJalr  = 7'b1100111;
   localparam logic [6:0] OpLui   = 7'b0110111;
   localparam logic [6:0] OpAuipc = 7'b0010111;

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StMemAdr = 4'd2,
      StMemRd  = 4'd3,
      StMemWb  = 4'd4,
      StMemWr  = 4'd5,
      StExec   = 4'd6,
      StAluWb  = 4'd7,
      StBranch = 4'd8,
      StJal    = 4'd9,
      StJalr   = 4'd10,
      StUpper  = 4'd11,
      StLink   = 4'd12,
      StTrap   = 4'd15
   } state_t;

   state_t          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            illegal_q, timeout_q;
   logic            ill_now, to_now, wait_st, take;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StFetch;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_q | ill_now;
         timeout_q <= timeout_q | to_now;
      end
   end

   always_comb begin
      mem_req   = 1'b0;
      MemWrite  = 1'b0;
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      RegWrite  = 1'b0;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      ResultSrc = 2'b00;
      ImmSrc    = 3'b000;
      state_d   = state_q;
      ill_now   = 1'b0;
      to_now    = 1'b0;
      wait_st   = 1'b0;
      take      = 1'b0;

      case (state_q)
         StFetch: begin
            mem_req = 1'b1;
            ALUSrcB = 2'b10;
            wait_st = 1'b1;
            if (mem_ready) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               state_d = StDecode;
            end
         end
         StDecode: begin
            // Precompute OldPC + imm so JAL/branch targets are ready in ALUOut.
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ImmSrc  = (op == OpJal) ? 3'b011 : 3'b010;
            case (op)
               OpLoad, OpStore: state_d = StMemAdr;
               OpR, OpI:        state_d = StExec;
               OpBr:            state_d = StBranch;
               OpJal:           state_d = StJal;
               OpJalr:          state_d = StJalr;
               OpLui, OpAuipc:  state_d = StUpper;
               default:         ill_now = 1'b1;
            endcase
         end
         StMemAdr: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            ImmSrc  = op[5] ? 3'b001 : 3'b000;
            state_d = op[5] ? StMemWr : StMemRd;
         end
         StMemRd: begin
            mem_req = 1'b1;
            AdrSrc  = 1'b1;
            wait_st = 1'b1;
            if (mem_ready) state_d = StMemWb;
         end
         StMemWr: begin
            mem_req  = 1'b1;
            MemWrite = 1'b1;
            AdrSrc   = 1'b1;
            wait_st  = 1'b1;
            if (mem_ready) state_d = StFetch;
         end
         StMemWb: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
            state_d   = StFetch;
         end
         StExec: begin
            ALUSrcA = 2'b01;
            ALUOp   = 2'b10;
            if (!op[5]) begin
               ALUSrcB = 2'b01;
               ImmSrc  = 3'b000;
            end
            state_d = StAluWb;
         end
         StAluWb: begin
            RegWrite = 1'b1;
            state_d  = StFetch;
         end
         StBranch: begin
            ALUSrcA = 2'b01;
            ALUOp   = 2'b01;
            case (funct3)
               3'b000:  take = Zero;
               3'b001:  take = !Zero;
               3'b100:  take = ALUR31;
               3'b101:  take = !ALUR31;
               3'b110:  take = !carryout;
               3'b111:  take = carryout;
               default: ill_now = 1'b1;
            endcase
            PCWrite = take;
            state_d = StFetch;
         end
         StJal: begin
            PCWrite = 1'b1;
            state_d = StLink;
         end
         StJalr: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            if (funct3 != 3'b000) ill_now = 1'b1;
            else                  PCWrite = 1'b1;
            state_d = StLink;
         end
         StLink: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b10;
            state_d = StAluWb;
         end
         StUpper: begin
            ImmSrc   = 3'b100;
            RegWrite = 1'b1;
            if (op[5]) begin
               ResultSrc = 2'b11;
            end else begin
               ALUSrcA   = 2'b10;
               ALUSrcB   = 2'b01;
               ResultSrc = 2'b10;
            end
            state_d = StFetch;
         end
         StTrap:  state_d = StTrap;
         default: state_d = StTrap;
      endcase

      if (ill_now) begin
         PCWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
         state_d  = TRAP_ON_ILLEGAL ? StTrap : StFetch;
      end

      // A ready in the last allowed cycle still completes the access.
      if (wait_st && !mem_ready && (MEM_WAIT_MAX != 0) && (cnt_q == WaitMax)) begin
         to_now  = 1'b1;
         state_d = StTrap;
      end

      cnt_d = (wait_st && (state_d == state_q)) ? cnt_q + CntW'(1) : '0;

      if (reset) begin
         mem_req   = 1'b0;
         MemWrite  = 1'b0;
         AdrSrc    = 1'b0;
         IRWrite   = 1'b0;
         PCWrite   = 1'b0;
         RegWrite  = 1'b0;
         ALUSrcA   = 2'b00;
         ALUSrcB   = 2'b00;
         ALUOp     = 2'b00;
         ResultSrc = 2'b00;
         ImmSrc    = 3'b000;
      end
   end

   assign state   = state_q;
   assign illegal = illegal_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: expected outputs are queued per cycle and checked at negedge.
// Instance a traps (MEM_WAIT_MAX=3), instance b retires illegal instructions as NOP.
module tb_mc_control_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       Zero, ALUR31, carryout, mem_ready;

   logic       a_mem_req, a_MemWrite, a_AdrSrc, a_IRWrite, a_PCWrite, a_RegWrite;
   logic [1:0] a_ALUSrcA, a_ALUSrcB, a_ALUOp, a_ResultSrc;
   logic [2:0] a_ImmSrc;
   logic [3:0] a_state;
   logic       a_illegal, a_timeout;

   logic       b_mem_req, b_MemWrite, b_AdrSrc, b_IRWrite, b_PCWrite, b_RegWrite;
   logic [1:0] b_ALUSrcA, b_ALUSrcB, b_ALUOp, b_ResultSrc;
   logic [2:0] b_ImmSrc;
   logic [3:0] b_state;
   logic       b_illegal, b_timeout;

   always #5 clk = ~clk;

   mc_control_fsm #(.MEM_WAIT_MAX(3), .TRAP_ON_ILLEGAL(1'b1)) u_a (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .Zero(Zero), .ALUR31(ALUR31),
      .carryout(carryout), .mem_ready(mem_ready), .mem_req(a_mem_req), .MemWrite(a_MemWrite),
      .AdrSrc(a_AdrSrc), .IRWrite(a_IRWrite), .PCWrite(a_PCWrite), .RegWrite(a_RegWrite),
      .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB), .ALUOp(a_ALUOp), .ResultSrc(a_ResultSrc),
      .ImmSrc(a_ImmSrc), .state(a_state), .illegal(a_illegal), .timeout(a_timeout)
   );

   mc_control_fsm #(.MEM_WAIT_MAX(15), .TRAP_ON_ILLEGAL(1'b0)) u_b (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .Zero(Zero), .ALUR31(ALUR31),
      .carryout(carryout), .mem_ready(mem_ready), .mem_req(b_mem_req), .MemWrite(b_MemWrite),
      .AdrSrc(b_AdrSrc), .IRWrite(b_IRWrite), .PCWrite(b_PCWrite), .RegWrite(b_RegWrite),
      .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB), .ALUOp(b_ALUOp), .ResultSrc(b_ResultSrc),
      .ImmSrc(b_ImmSrc), .state(b_state), .illegal(b_illegal), .timeout(b_timeout)
   );

   typedef struct packed {
      logic [3:0] st;
      logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
      logic [1:0] srca, srcb, aluop, ressrc;
      logic [2:0] immsrc;
      logic       illegal, timeout;
   } obs_t;

   typedef struct {
      string tag;
      int    inst;
      obs_t  exp;
   } sb_t;

   sb_t sbq[$];
   int  errors = 0;
   int  checks = 0;

   function automatic obs_t obs_of(int inst);
      obs_t o;
      if (inst == 0)
         o = '{a_state, a_mem_req, a_MemWrite, a_AdrSrc, a_IRWrite, a_PCWrite, a_RegWrite,
               a_ALUSrcA, a_ALUSrcB, a_ALUOp, a_ResultSrc, a_ImmSrc, a_illegal, a_timeout};
      else
         o = '{b_state, b_mem_req, b_MemWrite, b_AdrSrc, b_IRWrite, b_PCWrite, b_RegWrite,
               b_ALUSrcA, b_ALUSrcB, b_ALUOp, b_ResultSrc, b_ImmSrc, b_illegal, b_timeout};
      return o;
   endfunction

   function automatic obs_t mk(logic [3:0] st);
      obs_t e;
      e    = '0;
      e.st = st;
      return e;
   endfunction

   function automatic obs_t fetch_e(logic rdy);
      obs_t e;
      e          = mk(4'd0);
      e.mem_req  = 1'b1;
      e.srcb     = 2'b10;
      e.ir_write = rdy;
      e.pc_write = rdy;
      return e;
   endfunction

   task automatic push_exp(input string tag, input int inst, input obs_t e);
      sb_t it;
      it.tag  = tag;
      it.inst = inst;
      it.exp  = e;
      sbq.push_back(it);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard drain: all expectations queued this cycle are compared mid-cycle.
   always @(negedge clk) begin
      sb_t  it;
      obs_t got;
      while (sbq.size() > 0) begin
         it  = sbq.pop_front();
         got = obs_of(it.inst);
         checks++;
         assert (got === it.exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", it.tag, got, it.exp);
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      obs_t e;
      reset = 1'b1; op = 7'b0000011; funct3 = 3'b010;
      Zero = 1'b0; ALUR31 = 1'b0; carryout = 1'b0; mem_ready = 1'b1;
      tick;
      push_exp("reset_a", 0, mk(4'd0));
      push_exp("reset_b", 1, mk(4'd0));
      tick;
      reset = 1'b0;

      // load: 0,1,2,3,4,0
      push_exp("ld_fetch", 0, fetch_e(1'b1)); tick;
      e = mk(4'd1); e.srca = 2; e.srcb = 1; e.immsrc = 3'b010; push_exp("ld_decode", 0, e); tick;
      e = mk(4'd2); e.srca = 1; e.srcb = 1; push_exp("ld_memadr", 0, e); tick;
      e = mk(4'd3); e.mem_req = 1; e.adr_src = 1; push_exp("ld_memrd", 0, e); tick;
      e = mk(4'd4); e.ressrc = 2'b01; e.reg_write = 1; push_exp("ld_memwb", 0, e); tick;

      // store
      op = 7'b0100011;
      push_exp("st_fetch", 0, fetch_e(1'b1)); tick;
      tick;
      e = mk(4'd2); e.srca = 1; e.srcb = 1; e.immsrc = 3'b001; push_exp("st_memadr", 0, e); tick;
      e = mk(4'd5); e.mem_req = 1; e.mem_write = 1; e.adr_src = 1; push_exp("st_memwr", 0, e);
      tick;

      // R-type and I-type ALU
      op = 7'b0110011; tick; tick;
      e = mk(4'd6); e.srca = 1; e.aluop = 2'b10; push_exp("r_exec", 0, e); tick;
      e = mk(4'd7); e.reg_write = 1; push_exp("r_aluwb", 0, e); tick;
      op = 7'b0010011; tick; tick;
      e = mk(4'd6); e.srca = 1; e.srcb = 1; e.aluop = 2'b10; push_exp("i_exec", 0, e); tick;
      tick;

      // branches
      op = 7'b1100011; funct3 = 3'b110; carryout = 1'b0; tick; tick;
      e = mk(4'd8); e.srca = 1; e.aluop = 2'b01; e.pc_write = 1; push_exp("bltu_take", 0, e);
      tick;
      carryout = 1'b1; tick; tick;
      e.pc_write = 0; push_exp("bltu_not", 0, e); tick;
      funct3 = 3'b000; Zero = 1'b1; carryout = 1'b0; tick; tick;
      e.pc_write = 1; push_exp("beq_take", 0, e); tick;
      Zero = 1'b0;

      // jalr then jal
      op = 7'b1100111; funct3 = 3'b000; tick; tick;
      e = mk(4'd10); e.srca = 1; e.srcb = 1; e.ressrc = 2'b10; e.pc_write = 1;
      push_exp("jalr", 0, e); tick;
      e = mk(4'd12); e.srca = 2; e.srcb = 2; push_exp("jalr_link", 0, e); tick;
      e = mk(4'd7); e.reg_write = 1; push_exp("jalr_aluwb", 0, e); tick;
      op = 7'b1101111;
      push_exp("jalr_fetch", 0, fetch_e(1'b1)); tick;
      e = mk(4'd1); e.srca = 2; e.srcb = 1; e.immsrc = 3'b011; push_exp("jal_decode", 0, e);
      tick;
      e = mk(4'd9); e.pc_write = 1; push_exp("jal", 0, e); tick;
      tick; tick;

      // lui, auipc
      op = 7'b0110111; tick; tick;
      e = mk(4'd11); e.immsrc = 3'b100; e.reg_write = 1; e.ressrc = 2'b11; push_exp("lui", 0, e);
      tick;
      op = 7'b0010111; tick; tick;
      e = mk(4'd11); e.srca = 2; e.srcb = 1; e.immsrc = 3'b100; e.ressrc = 2'b10;
      e.reg_write = 1; push_exp("auipc", 0, e); tick;

      // fetch stalled 3 cycles, ready on the 4th: no timeout
      op = 7'b0110111; mem_ready = 1'b0;
      push_exp("wait_c1", 0, fetch_e(1'b0)); tick;
      tick; tick;
      mem_ready = 1'b1;
      push_exp("wait_c4", 0, fetch_e(1'b1)); tick;
      e = mk(4'd1); e.srca = 2; e.srcb = 1; e.immsrc = 3'b010; push_exp("wait_decode", 0, e);
      tick; tick;

      // reset during a stalled store
      op = 7'b0100011; tick; tick; tick;
      mem_ready = 1'b0;
      e = mk(4'd5); e.mem_req = 1; e.mem_write = 1; e.adr_src = 1; push_exp("stall_memwr", 0, e);
      tick;
      reset = 1'b1;
      push_exp("rst_memwr", 0, mk(4'd0)); tick;
      reset = 1'b0; mem_ready = 1'b1;
      push_exp("rst_release", 0, fetch_e(1'b1)); tick;

      // illegal branch funct3
      op = 7'b1100011; funct3 = 3'b010; tick;
      e = mk(4'd8); e.srca = 1; e.aluop = 2'b01;
      push_exp("bill_branch_a", 0, e); push_exp("bill_branch_b", 1, e); tick;
      e = mk(4'd15); e.illegal = 1; push_exp("bill_trap_a", 0, e);
      e = fetch_e(1'b1); e.illegal = 1; push_exp("bill_fetch_b", 1, e); tick;
      e = mk(4'd15); e.illegal = 1; push_exp("trap_hold", 0, e); tick;

      // illegal opcode
      reset = 1'b1; tick;
      reset = 1'b0; op = 7'b1111111; funct3 = 3'b000;
      push_exp("iop_fetch_b", 1, fetch_e(1'b1)); tick;
      e = mk(4'd1); e.srca = 2; e.srcb = 1; e.immsrc = 3'b010; push_exp("iop_decode_b", 1, e);
      tick;
      e = fetch_e(1'b1); e.illegal = 1; push_exp("iop_nop_b", 1, e);
      e = mk(4'd15); e.illegal = 1; push_exp("iop_trap_a", 0, e); tick;

      // fetch timeout
      reset = 1'b1; tick;
      reset = 1'b0; mem_ready = 1'b0;
      push_exp("to_c1", 0, fetch_e(1'b0)); tick;
      tick; tick;
      push_exp("to_c4", 0, fetch_e(1'b0)); tick;
      e = mk(4'd15); e.timeout = 1; push_exp("to_trap_a", 0, e);
      push_exp("to_wait_b", 1, fetch_e(1'b0)); tick;
      tick;

      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: observed=%0d pending expected=0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
